// File: rtl/scoreboard_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : scoreboard_reg_file
//  Purpose  : Parametrised multi-read-port register file with a per-register
//             busy scoreboard for the pipelined MIPS datapath. Register 0 is
//             hardwired to zero and can never be marked busy.
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             we/wr_addr/wr_data    - single write port
//             rd_addr/rd_data       - NUM_RD packed combinational read ports
//             rd_busy               - busy flag of each read port's register
//             rsv_en/rsv_addr       - reserve (mark busy) a destination reg
//             flush                 - clear every busy bit
//             busy_cnt              - registered count of busy registers
//  Config   : define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
//  Revision : 1.0 - initial release
// ============================================================================
module scoreboard_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_wr_ok;

  // Writes to r0 are dropped, so r_mem[0] stays at its reset value of zero.
  assign w_wr_ok = we && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Next busy vector. Ordering gives the priorities: a completing write
  // clears, a reservation in the same cycle re-sets (newer producer), and a
  // flush wipes everything.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end
    if (rsv_en) begin
      w_busy_nxt[rsv_addr] = 1'b1;
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Popcount of the next value so busy_cnt tracks r_busy in the same cycle.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= '0;
      busy_cnt <= '0;
    end else begin
      r_busy   <= w_busy_nxt;
      busy_cnt <= w_cnt_nxt;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; suppressed while reset is held so reads
    // stay zero during reset.
    logic w_hit;
    assign w_hit = rst_n && w_wr_ok && (w_addr == wr_addr);
    assign rd_data[gi*DATA_W +: DATA_W] = w_hit ? wr_data : r_mem[w_addr];
    assign rd_busy[gi] = w_hit ? (rsv_en && (rsv_addr == wr_addr))
                               : r_busy[w_addr];
`else
    assign rd_data[gi*DATA_W +: DATA_W] = r_mem[w_addr];
    assign rd_busy[gi] = r_busy[w_addr];
`endif
  end : g_rd

endmodule
`default_nettype wire
